// File: rtl/key_debounce_if.sv
// Key-side bus of the play-mode front end: raw active-low keys in, one-hot press code
// and busy flag out. The debouncer takes the slave side.
interface key_debounce_if;
    logic [3:0] key_n;
    logic [3:0] switch;
    logic       key_busy;

    modport master (
        output key_n,
        input  switch,
        input  key_busy
    );

    modport slave (
        input  key_n,
        output switch,
        output key_busy
    );
endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces four active-low keys into a one-cycle one-hot press code.
// Optional feature macro: AUTO_REPEAT_EN (periodic re-pulse while a single key is held).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int CNT_W           = 25
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce_if.slave  kbus
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        FILTER_DN = 2'b01,
        HELD      = 2'b10,
        FILTER_UP = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations whose terminal counts cannot be represented in CNT_W bits.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        ((64'(DEBOUNCE_CYCLES) - 64'd1) >> CNT_W) != 64'd0 ||
        ((64'(REPEAT_CYCLES) - 64'd1) >> CNT_W) != 64'd0) begin : g_bad_cfg
        $error("key_debounce: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
    end

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       key_act_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       code_r;
    logic [3:0]       switch_r;
    logic             busy_r;

    // Two-flop synchroniser; reset value means "all keys released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= kbus.key_n;
            sync2_r <= sync1_r;
        end
    end

    assign key_act_s = ~sync2_r;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rpt_r;
`endif

    // Debounce FSM with registered press pulse and busy flag (busy mirrors state != IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            code_r   <= 4'b0000;
            switch_r <= 4'b0000;
            busy_r   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_r    <= CNT_ZERO;
`endif
        end else begin
            switch_r <= 4'b0000;
            busy_r   <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (key_act_s != 4'b0000) begin
                        state_r <= FILTER_DN;
                        code_r  <= key_act_s;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                FILTER_DN: begin
                    if (key_act_s != code_r) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == DB_LAST) begin
                        state_r <= HELD;
                        cnt_r   <= CNT_ZERO;
                        // Chords settle into HELD silently so a later release is still filtered.
                        if (is_one_hot(code_r)) begin
                            switch_r <= code_r;
                        end else begin
                            switch_r <= 4'b0000;
                        end
`ifdef AUTO_REPEAT_EN
                        rpt_r   <= CNT_ZERO;
`endif
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                HELD: begin
                    if (key_act_s == 4'b0000) begin
                        state_r <= FILTER_UP;
                        cnt_r   <= CNT_ZERO;
`ifdef AUTO_REPEAT_EN
                        rpt_r   <= CNT_ZERO;
`endif
                    end else begin
                        state_r <= HELD;
`ifdef AUTO_REPEAT_EN
                        // Repeat only while the original single key is the one held.
                        if (is_one_hot(code_r) && key_act_s == code_r) begin
                            if (rpt_r == RPT_LAST) begin
                                switch_r <= code_r;
                                rpt_r    <= CNT_ZERO;
                            end else begin
                                rpt_r    <= rpt_r + CNT_ONE;
                            end
                        end else begin
                            rpt_r <= CNT_ZERO;
                        end
`endif
                    end
                end
                FILTER_UP: begin
                    if (key_act_s != 4'b0000) begin
                        state_r <= HELD;
                        cnt_r   <= CNT_ZERO;
`ifdef AUTO_REPEAT_EN
                        rpt_r   <= CNT_ZERO;
`endif
                    end else if (cnt_r == DB_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    code_r  <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign kbus.switch   = switch_r;
    assign kbus.key_busy = busy_r;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key traffic,
// all checked cycle by cycle against a run-length reference model.
module tb_key_debounce;

    localparam int D = 4;
    localparam int R = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R),
        .CNT_W          (25)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kbus (kif.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a press is accepted after D+1 consecutive identical nonzero
    // samples, a release after D+1 consecutive zero samples.
    logic [3:0] m_s1, m_s2, cand, exp_sw;
    logic       exp_busy, armed;
    int         run, relrun, rep;

    logic [3:0] stim[$];
    int         pidx[$];
    logic [3:0] pcode[$];
    logic       bhist[$];

    function automatic void model_reset();
        m_s1 = 4'b1111; m_s2 = 4'b1111; cand = 4'b0000;
        armed = 1'b1; run = 0; relrun = 0; rep = 0;
        exp_sw = 4'b0000; exp_busy = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] k);
        logic [3:0] act;
        act = ~m_s2; m_s2 = m_s1; m_s1 = k;
        exp_sw = 4'b0000;
        if (armed) begin
            if (run == 0) begin
                if (act != 4'b0000) begin cand = act; run = 1; end
            end else if (act != cand) begin
                run = 0;
            end else begin
                run++;
                if (run == D + 1) begin
                    if ($countones(cand) == 1) exp_sw = cand;
                    armed = 1'b0; run = 0; relrun = 0; rep = 0;
                end
            end
        end else if (act == 4'b0000) begin
            relrun++; rep = 0;
            if (relrun == D + 1) begin armed = 1'b1; run = 0; relrun = 0; end
        end else if (relrun > 0) begin
            relrun = 0; rep = 0;
        end else begin
`ifdef AUTO_REPEAT_EN
            if ($countones(cand) == 1 && act == cand) begin
                rep++;
                if (rep == R) begin exp_sw = cand; rep = 0; end
            end else begin
                rep = 0;
            end
`endif
        end
        exp_busy = !armed || (run > 0);
    endfunction

    task automatic step(input logic [3:0] k);
        kif.key_n = k;
        @(posedge clk);
        model_edge(k);
        #1;
    endtask

    task automatic clear_logs();
        stim.delete(); pidx.delete(); pcode.delete(); bhist.delete();
    endtask

    task automatic push_n(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) stim.push_back(k);
    endtask

    task automatic test_reset();
        clear_logs();
        rst_n = 1'b0; kif.key_n = 4'b1111; model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (kif.switch !== 4'b0000 || kif.key_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init: switch=%b key_busy=%b expected 0000/0", kif.switch, kif.key_busy);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b0111);
        vectors++;
        if (kif.key_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_before: key_busy=%b expected 1", kif.key_busy);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (kif.switch !== 4'b0000 || kif.key_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: switch=%b key_busy=%b expected 0000/0", kif.switch, kif.key_busy);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        push_n(4'b0111, 12);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL reset cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
            if (kif.switch !== 4'b0000) begin pidx.push_back(i); pcode.push_back(kif.switch); end
        end
        vectors++;
        if (pidx.size() != 1 || pidx[0] != 6 || pcode[0] !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_pulse: pulses=%0d first_at=%0d expected 1 pulse 1000 at 6", pidx.size(), (pidx.size() > 0) ? pidx[0] : -1);
        end
    endtask

    task automatic test_clean_press();
        int first_busy;
        clear_logs();
        push_n(4'b1111, 14); push_n(4'b0111, 12);
        first_busy = -1;
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL clean_press cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
            if (kif.switch !== 4'b0000) begin pidx.push_back(i); pcode.push_back(kif.switch); end
            if (i >= 14 && first_busy < 0 && kif.key_busy === 1'b1) first_busy = i;
        end
        vectors++;
        if (pidx.size() != 1 || pidx[0] != 20 || pcode[0] !== 4'b1000 || first_busy != 16) begin
            miscompares++;
            $display("FAIL clean_press_timing: pulses=%0d at=%0d busy_from=%0d expected 1 pulse at 20, busy from 16", pidx.size(), (pidx.size() > 0) ? pidx[0] : -1, first_busy);
        end
    endtask

    task automatic test_bounce();
        clear_logs();
        push_n(4'b1111, 14);
        for (int j = 0; j < 20; j++) stim.push_back(((j / 2) % 2 == 0) ? 4'b0111 : 4'b1111);
        push_n(4'b0111, 14);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL bounce cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
            if (kif.switch !== 4'b0000) begin pidx.push_back(i); pcode.push_back(kif.switch); end
        end
        vectors++;
        if (pidx.size() != 1 || pidx[0] != 40 || pcode[0] !== 4'b1000) begin
            miscompares++;
            $display("FAIL bounce_pulse: pulses=%0d first_at=%0d expected 1 pulse 1000 at 40", pidx.size(), (pidx.size() > 0) ? pidx[0] : -1);
        end
    endtask

    task automatic test_release_bounce();
        clear_logs();
        push_n(4'b1111, 14); push_n(4'b1011, 100);
        for (int b = 0; b < 3; b++) begin push_n(4'b1111, 2); push_n(4'b1011, 2); end
        push_n(4'b1111, 14);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL release_bounce cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
            if (kif.switch !== 4'b0000) begin pidx.push_back(i); pcode.push_back(kif.switch); end
            bhist.push_back(kif.key_busy);
        end
        vectors++;
`ifdef AUTO_REPEAT_EN
        if (pidx.size() < 1 || pcode[0] !== 4'b0100 || bhist[bhist.size()-1] !== 1'b0) begin
`else
        if (pidx.size() != 1 || pcode[0] !== 4'b0100 || bhist[bhist.size()-1] !== 1'b0) begin
`endif
            miscompares++;
            $display("FAIL release_bounce_result: pulses=%0d code=%b final_busy=%b expected one 0100 pulse, busy 0", pidx.size(), (pcode.size() > 0) ? pcode[0] : 4'b0000, bhist[bhist.size()-1]);
        end
    endtask

    task automatic test_chord();
        clear_logs();
        push_n(4'b1111, 14); push_n(4'b0011, 20); push_n(4'b1111, 14); push_n(4'b1101, 12);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL chord cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
            if (kif.switch !== 4'b0000) begin pidx.push_back(i); pcode.push_back(kif.switch); end
            bhist.push_back(kif.key_busy);
        end
        vectors++;
        if (bhist[33] !== 1'b1 || pidx.size() != 1 || pidx[0] != 54 || pcode[0] !== 4'b0010) begin
            miscompares++;
            $display("FAIL chord_result: busy_at_33=%b pulses=%0d first_at=%0d expected busy 1, one 0010 pulse at 54", bhist[33], pidx.size(), (pidx.size() > 0) ? pidx[0] : -1);
        end
    endtask

    task automatic test_auto_repeat();
        int want[$];
        logic bad;
        clear_logs();
        push_n(4'b1111, 14); push_n(4'b0111, 47); push_n(4'b1111, 14);
`ifdef AUTO_REPEAT_EN
        want = '{20, 30, 40, 50, 60};
`else
        want = '{20};
`endif
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL auto_repeat cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
            if (kif.switch !== 4'b0000) begin pidx.push_back(i); pcode.push_back(kif.switch); end
        end
        bad = (pidx.size() != want.size());
        for (int i = 0; i < pidx.size() && !bad; i++)
            if (pidx[i] != want[i] || pcode[i] !== 4'b1000) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL auto_repeat_pulses: got %0d pulses, expected %0d (first expected at 20)", pidx.size(), want.size());
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        int len, sel;
        clear_logs();
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      k = 4'b1111;
            else if (sel < 8) k = ~(4'b0001 << $urandom_range(0, 3));
            else              k = 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
            push_n(k, len);
        end
        push_n(4'b1111, 14);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            vectors++;
            if (kif.switch !== exp_sw || kif.key_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL random cycle %0d: switch=%b key_busy=%b expected %b/%b", i, kif.switch, kif.key_busy, exp_sw, exp_busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        kif.key_n = 4'b1111;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_chord();
        test_auto_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
